mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM→WB pipeline stage register for the MIPS core.
- It replaces free-running stage capture with a valid/ready handshake backed by a two-slot skid buffer.
- It supports a synchronous flush and registers the writeback mux result and the write-enable qualification.
- It sits between the data-memory stage and the register-file write port.

Parameters:
- DATA_W, 32: width of read data, ALU result and writeback data.
- REG_ADDR_W, 5: width of the destination register index.
- SKID_EN, 1: 1 gives a two-slot skid buffer (full throughput, registered in_ready). 0 gives a single slot where in_ready = !out_valid | out_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_read_data  in  DATA_W  memory read data.
- in_alu_result  in  DATA_W  ALU result / address.
- in_reg_dest  in  REG_ADDR_W  destination register index.
- in_mem_to_reg  in  1  1 selects read data for writeback.
- in_reg_write  in  1  register-file write request.
- out_valid  out  1  output slot holds a valid entry.
- out_ready  in  1  writeback consumes the entry this cycle.
- out_read_data  out  DATA_W  held read data.
- out_alu_result  out  DATA_W  held ALU result.
- out_reg_dest  out  REG_ADDR_W  held destination index.
- out_mem_to_reg  out  1  held control bit.
- out_wb_data  out  DATA_W  writeback data: read data if mem_to_reg, else ALU result; computed at capture and registered.
- out_wb_we  out  1  out_valid & reg_write & (reg_dest != 0).
- occupancy  out  2  number of valid entries held (0..2; 0..1 when SKID_EN=0).

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all data/control registers 0, occupancy 0. in_ready reads 1 while rst=0 and in the first cycle after release.
- Storage: main slot M drives the out_* ports; skid slot S is used only when SKID_EN=1.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 when M is empty or draining.
- in_ready (SKID_EN=1) = !S.valid, driven directly from a flop (no combinational path from out_ready).
- Edge transitions, SKID_EN=1:
  - M empty, accept: M ← input.
  - M full, drain, no accept: M ← S if S.valid, else M.valid ← 0; S.valid ← 0.
  - M full, drain, accept: if S.valid then M ← S and S ← input, else M ← input.
  - M full, no drain, accept: S ← input (in_ready falls next cycle).
  - Both full, no drain: hold. in_ready=0, so no accept is possible.
- SKID_EN=0: single slot. in_ready = !M.valid | out_ready (combinational). Simultaneous drain and accept replaces M in the same edge.
- Ordering: strictly FIFO; entries never reorder or duplicate.
- Stability: while out_valid=1 and out_ready=0, every out_* port is stable.
- out_wb_data and out_wb_we are recomputed whenever M loads (from input or from S), never from stale fields.
- Register 0: writes to index 0 are held and passed through, but out_wb_we=0.
- Flush: on a rising edge with flush=1, M.valid and S.valid ← 0 and occupancy ← 0. An entry offered in the same cycle is discarded, regardless of in_ready. A drain in the same cycle still counts as consumed by downstream. Data fields are not cleared.
- Priority: rst > flush > normal transfer.
- Reset mid-operation: entries are lost immediately and outputs go to 0 asynchronously.
- occupancy = M.valid + S.valid, registered, updated on the same edge as the valid bits.

Test Plan:
- Streaming: SKID_EN=1, out_ready=1, 8 back-to-back entries with alu_result=0x10..0x17 and mem_to_reg=0 → out_wb_data 0x10..0x17 on consecutive cycles one cycle after each accept; in_ready stays 1; occupancy ≤1.
- Backpressure: out_ready=0 for 3 cycles while entries A and B are offered → occupancy 2 and in_ready=0 from the cycle after B; outputs hold A stable. Raising out_ready then drains A then B with no loss.
- Writeback mux and r0: read_data=0xDEADBEEF, alu=0x4, mem_to_reg=1, dest=5, reg_write=1 → wb_data=0xDEADBEEF, wb_we=1. The same entry with dest=0 → wb_we=0 and out_valid=1.
- Flush with both slots full, plus a simultaneous in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1; the offered entry never appears at the output.
- Async reset: assert rst low mid-cycle with occupancy 2 → out_valid, out_wb_we and occupancy go to 0 before the next edge. After release, the first accepted entry emerges after 1 cycle.
- SKID_EN=0: full slot with out_ready=1 and in_valid=1 on the same cycle → in_ready=1 combinationally, slot replaced, no bubble. With out_ready=0, in_ready=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB stage register with valid/ready handshake; one-cycle latency to the outputs.
// SKID_EN=1 gives a two-slot skid with in_ready from a flop; SKID_EN=0 gives a single slot with combinational in_ready.
module mem_wb_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int SKID_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_read_data,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [REG_ADDR_W-1:0] in_reg_dest,
   input  logic                  in_mem_to_reg,
   input  logic                  in_reg_write,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_read_data,
   output logic [DATA_W-1:0]     out_alu_result,
   output logic [REG_ADDR_W-1:0] out_reg_dest,
   output logic                  out_mem_to_reg,
   output logic [DATA_W-1:0]     out_wb_data,
   output logic                  out_wb_we,
   output logic [1:0]            occupancy
);

   typedef struct packed {
      logic [DATA_W-1:0]     rd;
      logic [DATA_W-1:0]     alu;
      logic [REG_ADDR_W-1:0] dest;
      logic                  m2r;
      logic                  we;
      logic [DATA_W-1:0]     wbd;
   } slot_t;

   slot_t      r_m;
   slot_t      r_s;
   slot_t      w_in;
   logic       r_m_vld;
   logic       r_s_vld;
   logic [1:0] r_occ;
   logic       w_accept;
   logic       w_drain;
   logic       w_m_vld_nxt;
   logic       w_s_vld_nxt;
   logic       w_m_ld_in;
   logic       w_m_ld_s;
   logic       w_s_ld;

   // Writeback mux and r0-qualified write enable are resolved before capture.
   always_comb begin
      w_in      = '0;
      w_in.rd   = in_read_data;
      w_in.alu  = in_alu_result;
      w_in.dest = in_reg_dest;
      w_in.m2r  = in_mem_to_reg;
      w_in.we   = in_reg_write & (in_reg_dest != '0);
      w_in.wbd  = in_mem_to_reg ? in_read_data : in_alu_result;
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = !r_s_vld;
      end else begin : g_single
         assign in_ready = !r_m_vld | out_ready;
      end
   endgenerate

   assign w_accept = in_valid & in_ready;
   assign w_drain  = r_m_vld & out_ready;

   // In single-slot mode an accept only happens when M is empty or draining,
   // so the skid branch below is never taken and S stays empty.
   always_comb begin
      w_m_vld_nxt = r_m_vld;
      w_s_vld_nxt = r_s_vld;
      w_m_ld_in   = 1'b0;
      w_m_ld_s    = 1'b0;
      w_s_ld      = 1'b0;
      if (flush) begin
         w_m_vld_nxt = 1'b0;
         w_s_vld_nxt = 1'b0;
      end else if (!r_m_vld || w_drain) begin
         if (r_s_vld) begin
            w_m_ld_s    = 1'b1;
            w_m_vld_nxt = 1'b1;
            w_s_ld      = w_accept;
            w_s_vld_nxt = w_accept;
         end else begin
            w_m_ld_in   = w_accept;
            w_m_vld_nxt = w_accept;
         end
      end else if (w_accept) begin
         w_s_ld      = 1'b1;
         w_s_vld_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m     <= '0;
         r_s     <= '0;
         r_m_vld <= 1'b0;
         r_s_vld <= 1'b0;
         r_occ   <= 2'd0;
      end else begin
         r_m_vld <= w_m_vld_nxt;
         r_s_vld <= w_s_vld_nxt;
         r_occ   <= {1'b0, w_m_vld_nxt} + {1'b0, w_s_vld_nxt};
         if (w_m_ld_s) begin
            r_m <= r_s;
         end else if (w_m_ld_in) begin
            r_m <= w_in;
         end
         if (w_s_ld) begin
            r_s <= w_in;
         end
      end
   end

   assign out_valid      = r_m_vld;
   assign out_read_data  = r_m.rd;
   assign out_alu_result = r_m.alu;
   assign out_reg_dest   = r_m.dest;
   assign out_mem_to_reg = r_m.m2r;
   assign out_wb_data    = r_m.wbd;
   assign out_wb_we      = r_m_vld & r_m.we;
   assign occupancy      = r_occ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: skid (SKID_EN=1) and single-slot (SKID_EN=0) instances side by side.
module tb_mem_wb_stage;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dest;
      logic        m2r;
      logic [31:0] wbd;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] t_rd = '0;
   logic [31:0] t_alu = '0;
   logic [4:0]  t_dest = '0;
   logic        t_m2r = 1'b0;
   logic        t_rw = 1'b0;

   logic        s1_flush = 1'b0, s1_in_valid = 1'b0, s1_out_ready = 1'b0;
   logic        s1_in_ready, s1_out_valid, s1_out_m2r, s1_out_we;
   logic [31:0] s1_out_rd, s1_out_alu, s1_out_wbd;
   logic [4:0]  s1_out_dest;
   logic [1:0]  s1_occ;

   logic        s0_flush = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
   logic        s0_in_ready, s0_out_valid, s0_out_m2r, s0_out_we;
   logic [31:0] s0_out_rd, s0_out_alu, s0_out_wbd;
   logic [4:0]  s0_out_dest;
   logic [1:0]  s0_occ;

   int   errors = 0;
   int   checks = 0;
   exp_t q1[$];
   exp_t q0[$];

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID_EN(1)) u_skid (
      .clk(clk), .rst(rst), .flush(s1_flush), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .in_read_data(t_rd), .in_alu_result(t_alu), .in_reg_dest(t_dest),
      .in_mem_to_reg(t_m2r), .in_reg_write(t_rw),
      .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_read_data(s1_out_rd),
      .out_alu_result(s1_out_alu), .out_reg_dest(s1_out_dest), .out_mem_to_reg(s1_out_m2r),
      .out_wb_data(s1_out_wbd), .out_wb_we(s1_out_we), .occupancy(s1_occ));

   mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID_EN(0)) u_single (
      .clk(clk), .rst(rst), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
      .in_read_data(t_rd), .in_alu_result(t_alu), .in_reg_dest(t_dest),
      .in_mem_to_reg(t_m2r), .in_reg_write(t_rw),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_read_data(s0_out_rd),
      .out_alu_result(s0_out_alu), .out_reg_dest(s0_out_dest), .out_mem_to_reg(s0_out_m2r),
      .out_wb_data(s0_out_wbd), .out_wb_we(s0_out_we), .occupancy(s0_occ));

   function automatic exp_t mk();
      exp_t e;
      e.rd   = t_rd;
      e.alu  = t_alu;
      e.dest = t_dest;
      e.m2r  = t_m2r;
      e.wbd  = t_m2r ? t_rd : t_alu;
      e.we   = t_rw && (t_dest != 5'd0);
      return e;
   endfunction

   task automatic drive(input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] dest,
                        input logic m2r, input logic rw);
      t_rd = rd; t_alu = alu; t_dest = dest; t_m2r = m2r; t_rw = rw;
   endtask

   // Scoreboard monitors, sampled one time unit before each rising edge.
   always @(negedge clk) begin
      exp_t obs;
      #4;
      if (!rst) begin
         q1.delete();
      end else begin
         checks++; if (s1_out_valid !== (q1.size() != 0)) begin errors++; $display("FAIL sb1_valid: got %b want %b", s1_out_valid, q1.size() != 0); end
         checks++; if (s1_occ !== 2'(q1.size())) begin errors++; $display("FAIL sb1_occ: got %0d want %0d", s1_occ, q1.size()); end
         checks++; if (s1_in_ready !== (q1.size() < 2)) begin errors++; $display("FAIL sb1_in_ready: got %b want %b", s1_in_ready, q1.size() < 2); end
         if (s1_out_valid && q1.size() != 0) begin
            obs = {s1_out_rd, s1_out_alu, s1_out_dest, s1_out_m2r, s1_out_wbd, s1_out_we};
            checks++; if (obs !== q1[0]) begin errors++; $display("FAIL sb1_head: got %h want %h", obs, q1[0]); end
            if (s1_out_ready) void'(q1.pop_front());
         end
         if (s1_flush) q1.delete();
         else if (s1_in_valid && s1_in_ready) q1.push_back(mk());
      end
   end

   always @(negedge clk) begin
      exp_t obs;
      #4;
      if (!rst) begin
         q0.delete();
      end else begin
         checks++; if (s0_out_valid !== (q0.size() != 0)) begin errors++; $display("FAIL sb0_valid: got %b want %b", s0_out_valid, q0.size() != 0); end
         checks++; if (s0_occ !== 2'(q0.size())) begin errors++; $display("FAIL sb0_occ: got %0d want %0d", s0_occ, q0.size()); end
         checks++; if (s0_in_ready !== (q0.size() == 0 || s0_out_ready)) begin errors++; $display("FAIL sb0_in_ready: got %b want %b", s0_in_ready, q0.size() == 0 || s0_out_ready); end
         if (s0_out_valid && q0.size() != 0) begin
            obs = {s0_out_rd, s0_out_alu, s0_out_dest, s0_out_m2r, s0_out_wbd, s0_out_we};
            checks++; if (obs !== q0[0]) begin errors++; $display("FAIL sb0_head: got %h want %h", obs, q0[0]); end
            if (s0_out_ready) void'(q0.pop_front());
         end
         if (s0_flush) q0.delete();
         else if (s0_in_valid && s0_in_ready) q0.push_back(mk());
      end
   end

   task automatic test_reset();
      #2;
      checks++; if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", s1_out_valid); end
      checks++; if (s1_occ !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", s1_occ); end
      checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", s1_in_ready); end
      checks++; if (s1_out_wbd !== 32'h0 || s1_out_we !== 1'b0) begin errors++; $display("FAIL rst_wb: got %h/%b want 0/0", s1_out_wbd, s1_out_we); end
      checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL rst_s0_in_ready: got %b want 1", s0_in_ready); end
      @(negedge clk); rst = 1'b1;
      #1;
      checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", s1_in_ready); end
   endtask

   task automatic test_streaming();
      s1_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, s1_in_ready); end
         checks++; if (s1_occ > 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want <=1", i, s1_occ); end
         if (i > 0) begin
            checks++; if (s1_out_valid !== 1'b1 || s1_out_wbd !== 32'h10 + 32'(i - 1)) begin errors++; $display("FAIL stream_wb[%0d]: got %b/%h want 1/%h", i, s1_out_valid, s1_out_wbd, 32'h10 + 32'(i - 1)); end
         end
         drive($urandom, 32'h10 + 32'(i), 5'(i + 1), 1'b0, 1'b1);
         s1_in_valid = 1'b1;
      end
      @(negedge clk); s1_in_valid = 1'b0;
      checks++; if (s1_out_wbd !== 32'h17) begin errors++; $display("FAIL stream_last: got %h want 00000017", s1_out_wbd); end
      @(negedge clk);
      checks++; if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", s1_out_valid); end
   endtask

   task automatic test_backpressure();
      @(negedge clk); s1_out_ready = 1'b0;
      drive(32'h1111, 32'hA0, 5'd3, 1'b0, 1'b1); s1_in_valid = 1'b1;
      @(negedge clk);
      checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b want 1", s1_in_ready); end
      drive(32'h2222, 32'hB0, 5'd4, 1'b0, 1'b1);
      @(negedge clk); s1_in_valid = 1'b0;
      checks++; if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b want 2/0", s1_occ, s1_in_ready); end
      checks++; if (s1_out_alu !== 32'hA0) begin errors++; $display("FAIL bp_hold_a: got %h want a0", s1_out_alu); end
      @(negedge clk);
      checks++; if (s1_out_alu !== 32'hA0 || s1_out_wbd !== 32'hA0 || s1_occ !== 2'd2) begin errors++; $display("FAIL bp_stable: got %h/%h/%0d want a0/a0/2", s1_out_alu, s1_out_wbd, s1_occ); end
      s1_out_ready = 1'b1;
      @(negedge clk);
      checks++; if (s1_out_alu !== 32'hB0 || s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_b: got %h/%0d/%b want b0/1/1", s1_out_alu, s1_occ, s1_in_ready); end
      @(negedge clk);
      checks++; if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin errors++; $display("FAIL bp_empty: got %b/%0d want 0/0", s1_out_valid, s1_occ); end
   endtask

   task automatic test_wb_mux();
      @(negedge clk); s1_out_ready = 1'b1;
      drive(32'hDEADBEEF, 32'h4, 5'd5, 1'b1, 1'b1); s1_in_valid = 1'b1;
      @(negedge clk);
      checks++; if (s1_out_wbd !== 32'hDEADBEEF || s1_out_we !== 1'b1) begin errors++; $display("FAIL mux_rd: got %h/%b want deadbeef/1", s1_out_wbd, s1_out_we); end
      drive(32'hDEADBEEF, 32'h4, 5'd0, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (s1_out_valid !== 1'b1 || s1_out_we !== 1'b0 || s1_out_dest !== 5'd0) begin errors++; $display("FAIL mux_r0: got v=%b we=%b d=%0d want 1/0/0", s1_out_valid, s1_out_we, s1_out_dest); end
      drive(32'hDEADBEEF, 32'h4, 5'd7, 1'b0, 1'b0);
      @(negedge clk); s1_in_valid = 1'b0;
      checks++; if (s1_out_wbd !== 32'h4 || s1_out_we !== 1'b0) begin errors++; $display("FAIL mux_alu: got %h/%b want 00000004/0", s1_out_wbd, s1_out_we); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      @(negedge clk); s1_out_ready = 1'b0;
      drive(32'h0, 32'hA1, 5'd1, 1'b0, 1'b1); s1_in_valid = 1'b1;
      @(negedge clk); drive(32'h0, 32'hB1, 5'd2, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (s1_occ !== 2'd2) begin errors++; $display("FAIL flush_pre: got %0d want 2", s1_occ); end
      drive(32'h0, 32'hCC, 5'd3, 1'b0, 1'b1); s1_flush = 1'b1;
      @(negedge clk); s1_flush = 1'b0; s1_in_valid = 1'b0;
      checks++; if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || s1_in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got v=%b occ=%0d rdy=%b want 0/0/1", s1_out_valid, s1_occ, s1_in_ready); end
      drive(32'h0, 32'hDD, 5'd4, 1'b0, 1'b1); s1_in_valid = 1'b1; s1_flush = 1'b1;
      @(negedge clk); s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b1;
      checks++; if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin errors++; $display("FAIL flush_offer: got v=%b occ=%0d want 0/0", s1_out_valid, s1_occ); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got %b want 0", i, s1_out_valid); end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); s1_out_ready = 1'b0;
      drive(32'h0, 32'hE1, 5'd9, 1'b0, 1'b1); s1_in_valid = 1'b1;
      @(negedge clk); drive(32'h0, 32'hE2, 5'd10, 1'b0, 1'b1);
      @(negedge clk); s1_in_valid = 1'b0;
      checks++; if (s1_occ !== 2'd2 || s1_out_we !== 1'b1) begin errors++; $display("FAIL arst_pre: got occ=%0d we=%b want 2/1", s1_occ, s1_out_we); end
      @(posedge clk); #2 rst = 1'b0;
      #1;
      checks++; if (s1_out_valid !== 1'b0 || s1_out_we !== 1'b0 || s1_occ !== 2'd0) begin errors++; $display("FAIL arst_async: got v=%b we=%b occ=%0d want 0/0/0", s1_out_valid, s1_out_we, s1_occ); end
      checks++; if (s1_out_alu !== 32'h0 || s1_out_wbd !== 32'h0) begin errors++; $display("FAIL arst_data: got %h/%h want 0/0", s1_out_alu, s1_out_wbd); end
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      checks++; if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL arst_release_rdy: got %b want 1", s1_in_ready); end
      drive(32'h0, 32'hE0, 5'd11, 1'b0, 1'b1); s1_in_valid = 1'b1; s1_out_ready = 1'b1;
      @(negedge clk); s1_in_valid = 1'b0;
      checks++; if (s1_out_valid !== 1'b1 || s1_out_alu !== 32'hE0) begin errors++; $display("FAIL arst_first: got %b/%h want 1/e0", s1_out_valid, s1_out_alu); end
      @(negedge clk);
      checks++; if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL arst_drained: got %b want 0", s1_out_valid); end
   endtask

   task automatic test_single_slot();
      @(negedge clk); s0_out_ready = 1'b0;
      drive(32'h0, 32'h50, 5'd1, 1'b0, 1'b1); s0_in_valid = 1'b1;
      #1;
      checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_rdy: got %b want 1", s0_in_ready); end
      @(negedge clk);
      checks++; if (s0_out_valid !== 1'b1 || s0_out_alu !== 32'h50) begin errors++; $display("FAIL s0_x: got %b/%h want 1/50", s0_out_valid, s0_out_alu); end
      drive(32'h0, 32'h51, 5'd2, 1'b0, 1'b1);
      #1;
      checks++; if (s0_in_ready !== 1'b0) begin errors++; $display("FAIL s0_full_rdy: got %b want 0", s0_in_ready); end
      @(negedge clk);
      checks++; if (s0_out_alu !== 32'h50) begin errors++; $display("FAIL s0_hold: got %h want 50", s0_out_alu); end
      s0_out_ready = 1'b1;
      #1;
      checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_pass_rdy: got %b want 1", s0_in_ready); end
      @(negedge clk);
      checks++; if (s0_out_valid !== 1'b1 || s0_out_alu !== 32'h51 || s0_occ !== 2'd1) begin errors++; $display("FAIL s0_replace: got %b/%h/%0d want 1/51/1", s0_out_valid, s0_out_alu, s0_occ); end
      drive(32'h0, 32'h52, 5'd3, 1'b0, 1'b1);
      @(negedge clk); s0_in_valid = 1'b0;
      checks++; if (s0_out_valid !== 1'b1 || s0_out_alu !== 32'h52) begin errors++; $display("FAIL s0_next: got %b/%h want 1/52", s0_out_valid, s0_out_alu); end
      @(negedge clk);
      checks++; if (s0_out_valid !== 1'b0 || s0_occ !== 2'd0) begin errors++; $display("FAIL s0_empty: got %b/%0d want 0/0", s0_out_valid, s0_occ); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_wb_mux();
      test_flush();
      test_async_reset();
      test_single_slot();
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
